branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_if.sv | 41 ++++
 rtl/branch_predictor.sv | 89 ++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side update bundle for the branch predictor.
interface bp_if #(
    parameter int WORD = 32
);
    logic [WORD-1:0] IF_PC;
    logic            predict;
    logic [WORD-1:0] pred_target;
    logic            upd_valid;
    logic [WORD-1:0] upd_PC;
    logic            upd_taken;
    logic [WORD-1:0] upd_target;
    logic            upd_mispredict;
    logic [WORD-1:0] stat_branches;
    logic [WORD-1:0] stat_mispredicts;

    modport master (
        output IF_PC,
        output upd_valid,
        output upd_PC,
        output upd_taken,
        output upd_target,
        output upd_mispredict,
        input  predict,
        input  pred_target,
        input  stat_branches,
        input  stat_mispredicts
    );

    modport slave (
        input  IF_PC,
        input  upd_valid,
        input  upd_PC,
        input  upd_taken,
        input  upd_target,
        input  upd_mispredict,
        output predict,
        output pred_target,
        output stat_branches,
        output stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters.
// Optional BP_STATS_EN adds resolved/mispredicted branch counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int WORD    = 32
) (
    input logic clk,
    input logic rst,
    bp_if.slave bp
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = WORD - 2 - IDXW;

    logic            valid_q [ENTRIES];
    logic [TAGW-1:0] tag_q   [ENTRIES];
    logic [WORD-1:0] tgt_q   [ENTRIES];
    logic [1:0]      cnt_q   [ENTRIES];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDXW-1:0] up_idx;
    logic [TAGW-1:0] up_tag;
    logic            up_hit;
    logic            unused_bits;

    assign lk_idx = bp.IF_PC[IDXW+1:2];
    assign lk_tag = bp.IF_PC[WORD-1:IDXW+2];
    assign up_idx = bp.upd_PC[IDXW+1:2];
    assign up_tag = bp.upd_PC[WORD-1:IDXW+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads registered state only, so a same-cycle update is not seen.
    assign bp.predict     = lk_hit && cnt_q[lk_idx][1];
    assign bp.pred_target = lk_hit ? tgt_q[lk_idx]
                                   : bp.IF_PC + WORD'(4);

    assign unused_bits = ^{bp.IF_PC[1:0], bp.upd_PC[1:0],
                           bp.upd_mispredict};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (bp.upd_valid) begin
            if (up_hit) begin
                if (bp.upd_taken) begin
                    if (cnt_q[up_idx] != 2'b11)
                        cnt_q[up_idx] <= cnt_q[up_idx] + 2'd1;
                    tgt_q[up_idx] <= bp.upd_target;
                end else if (cnt_q[up_idx] != 2'b00) begin
                    cnt_q[up_idx] <= cnt_q[up_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Allocate weakly taken, evicting any aliasing occupant.
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= bp.upd_target;
                cnt_q[up_idx]   <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [WORD-1:0] br_cnt_q;
    logic [WORD-1:0] mp_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (bp.upd_valid) begin
            br_cnt_q <= br_cnt_q + WORD'(1);
            if (bp.upd_mispredict)
                mp_cnt_q <= mp_cnt_q + WORD'(1);
        end
    end

    assign bp.stat_branches    = br_cnt_q;
    assign bp.stat_mispredicts = mp_cnt_q;
`else
    assign bp.stat_branches    = '0;
    assign bp.stat_mispredicts = '0;
`endif
endmodule
